regfile_rv32: RTL and testbench
===============================

# regfile_rv32

Integer register file for the RV32I core: 32 × 32-bit architectural registers x0..x31 with two combinational read ports (rs1, rs2) and one synchronous write port (rd). It sits between decode and execute and is built from the same synchronous-reset storage style as the datapath's pipeline registers. After reset, a clear sequencer zeroes x1..x31, one per cycle, and holds `busy` high until the sweep completes. Same-cycle write-to-read bypass lets decode see a value in the cycle it is written back.

## Interface
- XLEN, 32, data width.
- NREG, 32, number of architectural registers. Fixed at 32 for RV32I; other values are unsupported.
- AW, 5, register address width (log2 NREG).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1_addr  in  AW  read port 1 register index.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_addr  in  AW  read port 2 register index.
- rs2_data  out  XLEN  read port 2 data, combinational.
- we  in  1  write enable.
- rd_addr  in  AW  write register index.
- rd_data  in  XLEN  write data.
- busy  out  1  registered; high while the clear sweep runs.

## Operation
- FSM states: CLEAR, RUN.
- Reset: rst=1 at an edge sets state=CLEAR, clear pointer=1 and busy=1. The array is not touched in that cycle.
- CLEAR:
  - Each edge with rst=0 writes 0 to reg[ptr], then increments ptr.
  - At ptr=31 the edge writes reg[31]=0, sets state=RUN and busy=0.
  - we is ignored throughout CLEAR.
  - rs1_data and rs2_data are forced to 0 while busy=1.
- RUN:
  - A write occurs when we=1 and rd_addr≠0: reg[rd_addr] ← rd_data at the edge.
  - Writes to x0 are discarded.
- Read path, per port p (RUN only):
  - addr=0 → 0.
  - Otherwise, we=1 and rd_addr=addr → rd_data (bypass).
  - Otherwise → reg[addr].
- Both ports may read the same index, and either or both may hit the bypass in the same cycle.
- x0 is never stored and always reads 0. It needs no storage element.
- rst asserted mid-sweep or during RUN restarts the sweep from ptr=1. Partially cleared or written contents are irrelevant because every entry is cleared again.

## Timing
- Reset values: busy=1, state=CLEAR, ptr=1. rs1_data and rs2_data are 0 while busy.
- Clear latency: busy falls at the 31st rising edge with rst=0 after reset. It is observable low starting in cycle 32.
- Write latency: a write at edge N is visible through the array from cycle N+1. In cycle N itself it is visible through the bypass.
- Read latency: zero cycles, purely combinational from addr, we, rd_addr and rd_data.
- Simultaneous rst and we: rst wins and the write is dropped.
- The cycle where busy falls is the first cycle in which we is honored.

## Structure
- Shared package `rv32_pkg`:
  - XLEN, NREG, AW.
  - Register-index constant X0=0.
  - The enum `rf_state_t` {CLEAR, RUN}.
- Storage is an array of NREG-1 words covering x1..x31.
- One natural sub-module, `rf_clr_seq`, owns the FSM, the 5-bit clear pointer and busy. It outputs clr_we and clr_addr, which are muxed into the write port ahead of the user write.

## Test plan
- Reset then idle:
  - rst high for 2 cycles, then low.
  - busy=1 for exactly 31 cycles and falls at edge 31.
  - Every index 0..31 then reads 0.
- Write/readback:
  - Write x5=0xDEADBEEF.
  - Next cycle rs1=5 → 0xDEADBEEF and rs2=0 → 0.
- x0 protection:
  - we=1, rd=0, data=0xFFFFFFFF.
  - Following cycles: rs1=0 and rs2=0 → 0.
- Bypass:
  - Same cycle we=1, rd=7, data=0x12345678, rs1=7, rs2=7.
  - Both ports read 0x12345678 that cycle. Next cycle, with we=0, both still read 0x12345678.
- Write during clear is ignored:
  - we=1, rd=31, data=0xA5A5A5A5 at sweep cycle 3.
  - After busy falls, x31 reads 0.
- Reset mid-operation:
  - Write x10=0x1, then reassert rst at sweep cycle 10 of a new reset.
  - busy restarts with a full 31-cycle count, and x10 reads 0 afterward.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared constants and types for the RV32I integer register file.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] X0 = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clr_seq.sv
// Post-reset clear sequencer: walks x1..x31 one per cycle, then hands over.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | sweeping x1..x31 with zeros, busy=1, user writes ignored
// RUN   | sweep done, busy=0, user port owns the write path
module rf_clr_seq
  import rv32_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy
);

  localparam logic [AW-1:0] PTR_FIRST = AW'(1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(NREG - 1);

  rf_state_t     state;
  logic [AW-1:0] ptr;

  // Sweep FSM: pointer advances each edge in CLEAR; the x31 edge retires the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= PTR_FIRST;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == PTR_LAST) begin
            state <= RUN;
            busy  <= 1'b0;
            ptr   <= PTR_FIRST;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= CLEAR;
          ptr   <= PTR_FIRST;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // The reset cycle itself must leave the array untouched, hence the rst gate.
  always_comb begin
    clr_we   = (state == CLEAR) && !rst;
    clr_addr = ptr;
  end

endmodule

// File: rtl/regfile_rv32.sv
// RV32I integer register file: 2 combinational read ports, 1 write port,
// hardware clear sweep after reset, same-cycle write-to-read bypass.
module regfile_rv32
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            busy
);

  // x0 has no storage; entries cover x1..x31 only.
  logic [XLEN-1:0] mem [1:NREG-1];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  rf_clr_seq u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  logic user_wr;

  // User writes count only in RUN and never target x0.
  always_comb begin
    user_wr = we && !busy && (rd_addr != X0);
  end

  // Write port: clear sweep has priority over the user write; rst drops both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else if (user_wr) begin
        mem[rd_addr] <= rd_data;
      end
    end
  end

  // Read port 1: zero while busy or for x0, bypass on matching write, else array.
  always_comb begin
    rs1_data = '0;
    if (!busy && (rs1_addr != X0)) begin
      if (we && (rd_addr == rs1_addr)) begin
        rs1_data = rd_data;
      end else begin
        rs1_data = mem[rs1_addr];
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rs2_data = '0;
    if (!busy && (rs2_addr != X0)) begin
      if (we && (rd_addr == rs2_addr)) begin
        rs2_data = rd_data;
      end else begin
        rs2_data = mem[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_rv32.sv
// Self-checking bench for regfile_rv32 with a behavioural register model.
module tb_regfile_rv32;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;

  int tests;
  int fails;

  // Reference model: plain register array plus remaining clear edges.
  logic [31:0] model [32];
  int          clear_left;

  regfile_rv32 dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (clear_left > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && rd_addr == a) return rd_data;
    return model[a];
  endfunction

  // One rising edge; model follows the spec rules, then return to negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clear_left = 31;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (we && rd_addr != 5'd0) begin
      model[rd_addr] = rd_data;
    end
    @(negedge clk);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; we = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd9;
    tick(); tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL reset_busy got=%b exp=1", busy);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      fails++; $display("FAIL read_while_busy got=%h/%h exp=0", rs1_data, rs2_data);
    end
    wait_clear(n);
    tests++;
    if (n != 31) begin
      fails++; $display("FAIL clear_len got=%0d exp=31", n);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      tests++;
      if (rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr)) begin
        fails++; $display("FAIL post_clear_zero idx=%0d got=%h/%h exp=0", i, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    tick();
    we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0;
    #1;
    tests++;
    if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'h0) begin
      fails++; $display("FAIL write_read got=%h/%h exp=deadbeef/0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_x0();
    we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    tests++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      fails++; $display("FAIL x0_same_cycle got=%h/%h exp=0", rs1_data, rs2_data);
    end
    tick();
    we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        fails++; $display("FAIL x0_protect got=%h/%h exp=0", rs1_data, rs2_data);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    tests++;
    if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
      fails++; $display("FAIL bypass got=%h/%h exp=12345678", rs1_data, rs2_data);
    end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
      fails++; $display("FAIL bypass_stored got=%h/%h exp=12345678", rs1_data, rs2_data);
    end
  endtask

  task automatic test_clear_write_ignored();
    int n;
    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    we = 1'b1; rd_addr = 5'd31; rd_data = 32'hA5A5A5A5;
    tick();
    we = 1'b0;
    wait_clear(n);
    tests++;
    if (n != 28) begin
      fails++; $display("FAIL clear_len2 got=%0d exp=28", n);
    end
    rs1_addr = 5'd31; rs2_addr = 5'd31;
    #1;
    tests++;
    if (rs1_data !== 32'h0 || rs2_data !== exp_read(5'd31)) begin
      fails++; $display("FAIL clear_write_ignored got=%h exp=0", rs1_data);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    we = 1'b1; rd_addr = 5'd10; rd_data = 32'h1;
    tick();
    we = 1'b0; rs1_addr = 5'd10;
    #1;
    tests++;
    if (rs1_data !== 32'h1) begin
      fails++; $display("FAIL x10_write got=%h exp=1", rs1_data);
    end
    rst = 1'b1; we = 1'b1; rd_addr = 5'd12; rd_data = 32'h55;
    tick();
    rst = 1'b0; we = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n);
    tests++;
    if (n != 31) begin
      fails++; $display("FAIL restart_len got=%0d exp=31", n);
    end
    rs1_addr = 5'd10; rs2_addr = 5'd12;
    #1;
    tests++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      fails++; $display("FAIL x10_after_rst got=%h/%h exp=0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int k = 0; k < 400; k++) begin
      we       = ($urandom_range(0, 3) != 0);
      rd_addr  = 5'($urandom_range(0, 31));
      rd_data  = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_read(rs1_addr);
      e2 = exp_read(rs2_addr);
      tests++;
      if (rs1_data !== e1 || rs2_data !== e2 || busy !== 1'b0) begin
        fails++;
        $display("FAIL random k=%0d a=%0d/%0d got=%h/%h exp=%h/%h busy=%b", k, rs1_addr, rs2_addr, rs1_data, rs2_data, e1, e2, busy);
      end
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    clear_left = 31;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_random();
    test_clear_write_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
